fabric_simple: RTL and testbench



---
 rtl/fabric_simple.sv | 42 ++++
 tb/tb_fabric_simple.sv | 120 ++++++++++++
 2 files changed

// File: rtl/fabric_simple.sv
// fabric_simple: single-word register endpoint with one-cycle registered read/write responses
module fabric_simple #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             read_req,
  input  logic             write_req,
  input  logic [WIDTH-1:0] write_data,
  output logic [WIDTH-1:0] read_data,
  output logic             req_valid,
  output logic             resp_valid
);
  logic [WIDTH-1:0] mem_q, mem_d;
  logic [WIDTH-1:0] read_data_q, read_data_d;
  logic             req_valid_q, req_valid_d;
  logic             resp_valid_q, resp_valid_d;
  // next state: writes update the word, a simultaneous read sees the new data
  always_comb begin
    mem_d        = write_req ? write_data : mem_q;
    read_data_d  = read_req ? (write_req ? write_data : mem_q) : read_data_q;
    req_valid_d  = read_req | write_req;
    resp_valid_d = read_req | write_req;
  end
  // state and output registers, cleared immediately by rst
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      mem_q        <= '0;
      read_data_q  <= '0;
      req_valid_q  <= 1'b0;
      resp_valid_q <= 1'b0;
    end else begin
      mem_q        <= mem_d;
      read_data_q  <= read_data_d;
      req_valid_q  <= req_valid_d;
      resp_valid_q <= resp_valid_d;
    end
  end
  assign read_data  = read_data_q;
  assign req_valid  = req_valid_q;
  assign resp_valid = resp_valid_q;
endmodule

// File: tb/tb_fabric_simple.sv
// tb_fabric_simple: scoreboard bench for fabric_simple with directed vectors
module tb_fabric_simple;
  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        read_req = 1'b0;
  logic        write_req = 1'b0;
  logic [31:0] write_data = '0;
  logic [31:0] read_data;
  logic        req_valid;
  logic        resp_valid;
  int n_cmp = 0;
  int n_bad = 0;
  typedef struct {
    string       nm;
    logic [31:0] rd;
    logic        v;
  } exp_t;
  exp_t q[$];
  fabric_simple #(.WIDTH(32)) dut (
    .clk(clk), .rst(rst), .read_req(read_req), .write_req(write_req),
    .write_data(write_data), .read_data(read_data),
    .req_valid(req_valid), .resp_valid(resp_valid)
  );
  always #5 clk = ~clk;
  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask
  task automatic drive(input string nm, input logic r, input logic w, input logic [31:0] d,
                       input logic [31:0] rd, input logic v);
    exp_t e;
    @(negedge clk);
    read_req = r;
    write_req = w;
    write_data = d;
    e.nm = nm;
    e.rd = rd;
    e.v = v;
    q.push_back(e);
  endtask
  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (q.size() != 0) begin
        e = q.pop_front();
        chk({e.nm, ".read_data"}, read_data, e.rd);
        chk({e.nm, ".req_valid"}, {31'd0, req_valid}, {31'd0, e.v});
        chk({e.nm, ".resp_valid"}, {31'd0, resp_valid}, {31'd0, e.v});
      end else if (!rst && (req_valid || resp_valid)) begin
        n_cmp++;
        n_bad++;
        $display("FAIL unexpected_resp: req_valid %b resp_valid %b with no request", req_valid, resp_valid);
      end
    end
  end
  initial begin
    repeat (2) @(posedge clk);
    #1;
    chk("rst.read_data", read_data, 32'h0);
    chk("rst.req_valid", {31'd0, req_valid}, 32'h0);
    chk("rst.resp_valid", {31'd0, resp_valid}, 32'h0);
    @(negedge clk);
    rst = 1'b0;
    drive("idle0", 0, 0, 32'h0, 32'h0, 0);
    drive("wr_a5", 0, 1, 32'hA5A5A5A5, 32'h0, 1);
    drive("rd_a5", 1, 0, 32'h0, 32'hA5A5A5A5, 1);
    drive("rw_dead", 1, 1, 32'hDEADBEEF, 32'hDEADBEEF, 1);
    drive("rd_dead", 1, 0, 32'h0, 32'hDEADBEEF, 1);
    drive("idle1", 0, 0, 32'h0, 32'hDEADBEEF, 0);
    drive("idle_wdata", 0, 0, 32'h11111111, 32'hDEADBEEF, 0);
    drive("rd_after_ign", 1, 0, 32'h0, 32'hDEADBEEF, 1);
    drive("wr_cafe", 0, 1, 32'hCAFEF00D, 32'hDEADBEEF, 1);
    drive("b2b_rd0", 1, 0, 32'h0, 32'hCAFEF00D, 1);
    drive("b2b_rd1", 1, 0, 32'h0, 32'hCAFEF00D, 1);
    drive("b2b_rd2", 1, 0, 32'h0, 32'hCAFEF00D, 1);
    drive("rw_hold1", 1, 1, 32'h00000001, 32'h00000001, 1);
    drive("rw_hold2", 1, 1, 32'h00000002, 32'h00000002, 1);
    drive("wr_1234", 0, 1, 32'h12345678, 32'h00000002, 1);
    @(posedge clk);
    #3;
    read_req = 1'b0;
    write_req = 1'b0;
    rst = 1'b1;
    #1;
    chk("async.read_data", read_data, 32'h0);
    chk("async.req_valid", {31'd0, req_valid}, 32'h0);
    chk("async.resp_valid", {31'd0, resp_valid}, 32'h0);
    @(negedge clk);
    read_req = 1'b1;
    write_req = 1'b1;
    write_data = 32'hFFFFFFFF;
    @(posedge clk);
    #1;
    chk("rst_discard.read_data", read_data, 32'h0);
    chk("rst_discard.req_valid", {31'd0, req_valid}, 32'h0);
    @(negedge clk);
    read_req = 1'b0;
    write_req = 1'b0;
    rst = 1'b0;
    drive("rd_post_rst", 1, 0, 32'h0, 32'h0, 1);
    drive("idle_end", 0, 0, 32'h0, 32'h0, 0);
    @(negedge clk);
    read_req = 1'b0;
    write_req = 1'b0;
    for (int i = 0; i < 10 && q.size() != 0; i++) @(posedge clk);
    #2;
    if (q.size() != 0) begin
      n_cmp++;
      n_bad++;
      $display("FAIL drain: %0d expectations left, expected 0", q.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
